// File: rtl/aes_wddl_pkg.sv
// Shared encodings for the WDDL dual-rail to single-rail converter.
package aes_wddl_pkg;

  typedef enum logic [1:0] {
    ST_PRE  = 2'd0,
    ST_EVAL = 2'd1,
    ST_HOLD = 2'd2
  } wddl_state_e;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'b00,
    ERR_PRECHARGE  = 2'b01,
    ERR_INVALID    = 2'b10,
    ERR_INCOMPLETE = 2'b11
  } wddl_err_e;

endpackage

// File: rtl/wddl_dr2sr_if.sv
// Bundles the dual-rail input wave, the output handshake and the fault status.
interface wddl_dr2sr_if #(
  parameter int unsigned WIDTH     = 128,
  parameter int unsigned ERR_CNT_W = 8
);
  logic                 pre_in;
  logic [WIDTH-1:0]     d_p_in;
  logic [WIDTH-1:0]     d_n_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     d_out;
  logic                 err_pulse;
  logic [1:0]           err_code;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 err_clr;

  modport master (
    output pre_in, d_p_in, d_n_in, out_ready, err_clr,
    input  out_valid, d_out, err_pulse, err_code, err_cnt
  );

  modport slave (
    input  pre_in, d_p_in, d_n_in, out_ready, err_clr,
    output out_valid, d_out, err_pulse, err_code, err_cnt
  );
endinterface

// File: rtl/wddl_rail_check.sv
// Combinational reduction of WIDTH rail pairs into precharge/complete/invalid flags.
module wddl_rail_check #(
  parameter int unsigned WIDTH = 128
) (
  input  logic [WIDTH-1:0] d_p_in,
  input  logic [WIDTH-1:0] d_n_in,
  output logic             all_zero,
  output logic             all_complete,
  output logic             any_invalid
);

  always_comb begin
    all_zero     = ~|(d_p_in | d_n_in);
    all_complete = &(d_p_in ^ d_n_in);
    any_invalid  = |(d_p_in & d_n_in);
  end

endmodule

// File: rtl/wddl_dr2sr.sv
// Decodes a WDDL precharge/evaluate wave into a registered single-rail word with fault tracking.
module wddl_dr2sr
  import aes_wddl_pkg::*;
#(
  parameter int unsigned WIDTH     = 128,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pre_in,
  input  logic [WIDTH-1:0]     d_p_in,
  input  logic [WIDTH-1:0]     d_n_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     d_out,
  output logic                 err_pulse,
  output logic [1:0]           err_code,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 err_clr
);

  logic        all_zero;
  logic        all_complete;
  logic        any_invalid;

  wddl_state_e state_q, state_d;
  logic        armed_q, armed_d;
  logic        valid_d;
  logic        load;
  logic        fault;
  wddl_err_e   fault_code;

  wddl_rail_check #(.WIDTH(WIDTH)) u_rail_check (
    .d_p_in      (d_p_in),
    .d_n_in      (d_n_in),
    .all_zero    (all_zero),
    .all_complete(all_complete),
    .any_invalid (any_invalid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_PRE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    valid_d    = out_valid;
    load       = 1'b0;
    fault      = 1'b0;
    fault_code = ERR_NONE;
    case (state_q)
      ST_PRE: begin
        if (pre_in) begin
          if (all_zero) armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = ST_EVAL;
          armed_d = 1'b0;
        end else begin
          fault      = 1'b1;
          fault_code = ERR_PRECHARGE;
        end
      end
      ST_EVAL: begin
        // Invalid pairs dominate; completion outranks an early precharge.
        if (any_invalid) begin
          fault      = 1'b1;
          fault_code = ERR_INVALID;
          state_d    = ST_PRE;
        end else if (all_complete) begin
          load    = 1'b1;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end else if (pre_in) begin
          fault      = 1'b1;
          fault_code = ERR_INCOMPLETE;
          state_d    = ST_PRE;
        end
      end
      ST_HOLD: begin
        if (out_valid && out_ready) begin
          valid_d = 1'b0;
          state_d = ST_PRE;
        end
      end
      default: begin
        state_d = ST_PRE;
        armed_d = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      d_out     <= '0;
      err_pulse <= 1'b0;
      err_code  <= ERR_NONE;
      err_cnt   <= '0;
    end else begin
      out_valid <= valid_d;
      err_pulse <= fault;
      if (load) d_out <= d_p_in;
      if (fault) begin
        err_code <= fault_code;
        if (err_clr)       err_cnt <= {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        else if (!(&err_cnt)) err_cnt <= err_cnt + 1'b1;
      end else if (err_clr) begin
        err_code <= ERR_NONE;
        err_cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wddl_dr2sr.sv
// Directed bench for wddl_dr2sr at WIDTH=8: decode, hold, faults, saturation and reset.
module tb_wddl_dr2sr;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 8;

  logic clk;
  logic rst;

  wddl_dr2sr_if #(.WIDTH(W), .ERR_CNT_W(CW)) bus ();

  wddl_dr2sr #(.WIDTH(W), .ERR_CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .pre_in   (bus.pre_in),
    .d_p_in   (bus.d_p_in),
    .d_n_in   (bus.d_n_in),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready),
    .d_out    (bus.d_out),
    .err_pulse(bus.err_pulse),
    .err_code (bus.err_code),
    .err_cnt  (bus.err_cnt),
    .err_clr  (bus.err_clr)
  );

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pre, input logic [W-1:0] p, input logic [W-1:0] n);
    bus.pre_in = pre;
    bus.d_p_in = p;
    bus.d_n_in = n;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst           = 1'b0;
    bus.out_ready = 1'b0;
    bus.err_clr   = 1'b0;
    drive(1'b1, 8'h00, 8'h00);
    cyc();
    cyc();
    chk("rst_valid", {31'd0, bus.out_valid}, 0);
    chk("rst_dout",  {24'd0, bus.d_out}, 0);
    chk("rst_pulse", {31'd0, bus.err_pulse}, 0);
    chk("rst_code",  {30'd0, bus.err_code}, 0);
    chk("rst_cnt",   {24'd0, bus.err_cnt}, 0);

    // basic decode
    rst = 1'b1;
    cyc();
    drive(1'b0, 8'hA5, 8'h5A);
    cyc();
    chk("dec_valid_early", {31'd0, bus.out_valid}, 0);
    cyc();
    chk("dec_valid", {31'd0, bus.out_valid}, 1);
    chk("dec_dout",  {24'd0, bus.d_out}, 32'hA5);
    chk("dec_pulse", {31'd0, bus.err_pulse}, 0);

    // hold under back-pressure while a new wave passes
    for (int i = 0; i < 5; i++) begin
      if (i < 2) drive(1'b1, 8'h00, 8'h00);
      else       drive(1'b0, 8'h3C, 8'hC3);
      cyc();
      chk("hold_valid", {31'd0, bus.out_valid}, 1);
      chk("hold_dout",  {24'd0, bus.d_out}, 32'hA5);
      chk("hold_pulse", {31'd0, bus.err_pulse}, 0);
    end
    bus.out_ready = 1'b1;
    cyc();
    chk("hs_valid", {31'd0, bus.out_valid}, 0);
    chk("hs_dout",  {24'd0, bus.d_out}, 32'hA5);
    bus.out_ready = 1'b0;
    cyc();
    chk("drop_pulse", {31'd0, bus.err_pulse}, 1);
    chk("drop_code",  {30'd0, bus.err_code}, 1);
    chk("drop_cnt",   {24'd0, bus.err_cnt}, 1);
    chk("drop_valid", {31'd0, bus.out_valid}, 0);
    drive(1'b1, 8'h00, 8'h00);
    cyc();
    chk("drop_pulse_end", {31'd0, bus.err_pulse}, 0);
    bus.err_clr = 1'b1;
    cyc();
    bus.err_clr = 1'b0;
    chk("clr_cnt",  {24'd0, bus.err_cnt}, 0);
    chk("clr_code", {30'd0, bus.err_code}, 0);

    // invalid 1/1 on bit 3
    drive(1'b0, 8'h08, 8'h08);
    cyc();
    chk("inv_pre_pulse", {31'd0, bus.err_pulse}, 0);
    cyc();
    chk("inv_pulse", {31'd0, bus.err_pulse}, 1);
    chk("inv_code",  {30'd0, bus.err_code}, 2);
    chk("inv_cnt",   {24'd0, bus.err_cnt}, 1);
    chk("inv_valid", {31'd0, bus.out_valid}, 0);

    // precharge fault: p[0] stuck high during precharge
    drive(1'b1, 8'h01, 8'h00);
    cyc();
    chk("inv_pulse_end", {31'd0, bus.err_pulse}, 0);
    chk("inv_dout_kept", {24'd0, bus.d_out}, 32'hA5);
    drive(1'b0, 8'h01, 8'h00);
    cyc();
    chk("prech_pulse", {31'd0, bus.err_pulse}, 1);
    chk("prech_code",  {30'd0, bus.err_code}, 1);
    chk("prech_cnt",   {24'd0, bus.err_cnt}, 2);

    // incomplete fault: 7 of 8 bits complete when precharge returns
    drive(1'b1, 8'h00, 8'h00);
    cyc();
    drive(1'b0, 8'h7F, 8'h00);
    cyc();
    cyc();
    chk("wait_pulse", {31'd0, bus.err_pulse}, 0);
    chk("wait_valid", {31'd0, bus.out_valid}, 0);
    drive(1'b1, 8'h7F, 8'h00);
    cyc();
    chk("inc_pulse", {31'd0, bus.err_pulse}, 1);
    chk("inc_code",  {30'd0, bus.err_code}, 3);
    chk("inc_cnt",   {24'd0, bus.err_cnt}, 3);

    // 300 consecutive precharge faults saturate the counter
    drive(1'b0, 8'h00, 8'h00);
    for (int n = 1; n <= 300; n++) begin
      cyc();
      if (n == 251) chk("sat_254", {24'd0, bus.err_cnt}, 254);
      if (n == 252) chk("sat_255", {24'd0, bus.err_cnt}, 255);
    end
    chk("sat_cnt",  {24'd0, bus.err_cnt}, 255);
    chk("sat_code", {30'd0, bus.err_code}, 1);
    bus.err_clr = 1'b1;
    cyc();
    chk("clrflt_cnt",  {24'd0, bus.err_cnt}, 1);
    chk("clrflt_code", {30'd0, bus.err_code}, 1);
    drive(1'b1, 8'h00, 8'h00);
    cyc();
    bus.err_clr = 1'b0;
    chk("clr2_cnt",   {24'd0, bus.err_cnt}, 0);
    chk("clr2_code",  {30'd0, bus.err_code}, 0);
    chk("clr2_pulse", {31'd0, bus.err_pulse}, 0);

    // reset mid-HOLD
    drive(1'b0, 8'hC3, 8'h3C);
    cyc();
    cyc();
    chk("h2_valid", {31'd0, bus.out_valid}, 1);
    chk("h2_dout",  {24'd0, bus.d_out}, 32'hC3);
    rst = 1'b0;
    #1;
    chk("arst_valid", {31'd0, bus.out_valid}, 0);
    chk("arst_dout",  {24'd0, bus.d_out}, 0);
    drive(1'b1, 8'h00, 8'h00);
    cyc();
    rst = 1'b1;
    drive(1'b0, 8'h5A, 8'hA5);
    cyc();
    chk("post_rst_pulse", {31'd0, bus.err_pulse}, 1);
    chk("post_rst_code",  {30'd0, bus.err_code}, 1);
    chk("post_rst_cnt",   {24'd0, bus.err_cnt}, 1);
    chk("post_rst_valid", {31'd0, bus.out_valid}, 0);
    drive(1'b1, 8'h00, 8'h00);
    cyc();
    drive(1'b0, 8'h5A, 8'hA5);
    cyc();
    // completion coincides with precharge returning
    drive(1'b1, 8'h5A, 8'hA5);
    cyc();
    chk("win_valid", {31'd0, bus.out_valid}, 1);
    chk("win_dout",  {24'd0, bus.d_out}, 32'h5A);
    chk("win_pulse", {31'd0, bus.err_pulse}, 0);
    drive(1'b1, 8'h00, 8'h00);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    chk("end_valid", {31'd0, bus.out_valid}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
